// File: rtl/ann_pkg.sv
// Shared types and helpers for the ANN neuron datapath.
// ANN_LEAKY_RELU_EN (optional define) enables the leaky negative branch in ann_activation.
package ann_pkg;

   typedef enum logic [1:0] {IDLE, ACCUM, ACT, HOLD} state_t;

   localparam int DATA_W      = 8;
   localparam int Y_MAX       = 127;
   localparam int Y_MIN       = -128;
   localparam int LEAKY_EXTRA = 3;

   function automatic logic signed [7:0] saturate(input logic signed [31:0] v);
      if (v > Y_MAX)
         return 8'sd127;
      else if (v < Y_MIN)
         return -8'sd128;
      else
         return v[7:0];
   endfunction

endpackage

// File: rtl/ann_activation.sv
// Combinational activation: arithmetic shift, ReLU (or leaky ReLU under
// ANN_LEAKY_RELU_EN), then saturation to a signed byte.
module ann_activation #(
   parameter int ACC_W = 20,
   parameter int SHIFT = 4
) (
   input  logic [ACC_W-1:0] acc,
   output logic [7:0]       y
);
   import ann_pkg::*;

   logic signed [ACC_W-1:0] s;
   assign s = $signed(acc) >>> SHIFT;

`ifdef ANN_LEAKY_RELU_EN
   // Negative side is attenuated by a further 2^LEAKY_EXTRA instead of clamped.
   logic signed [ACC_W-1:0] leak;
   assign leak = $signed(acc) >>> (SHIFT + LEAKY_EXTRA);

   always_comb begin
      y = saturate(32'(s));
      if (s[ACC_W-1])
         y = saturate(32'(leak));
   end
`else
   always_comb begin
      y = saturate(32'(s));
      if (s[ACC_W-1])
         y = 8'd0;
   end
`endif

endmodule

// File: rtl/ann_neuron_mac.sv
// Single-neuron MAC stage: serial (x, w) pairs accumulated onto a shifted bias,
// then activated and held for a valid/ready output handshake.
module ann_neuron_mac #(
   parameter int N_INPUTS = 4,
   parameter int DATA_W   = 8,
   parameter int ACC_W    = 20,
   parameter int SHIFT    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              bias_wr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] x_in,
   input  logic [DATA_W-1:0] w_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] y_out,
   output logic              busy
);
   import ann_pkg::*;

   localparam int CNT_W = $clog2(N_INPUTS + 1);

   if (ACC_W < 2*DATA_W + $clog2(N_INPUTS) + 1 || ACC_W > 32)
      $error("ann_neuron_mac: ACC_W too small for DATA_W/N_INPUTS (or above 32)");
   if (N_INPUTS < 1 || N_INPUTS > 16)
      $error("ann_neuron_mac: N_INPUTS must be 1..16");

   state_t                   state, state_nx;
   logic signed [ACC_W-1:0]  acc;
   logic [CNT_W-1:0]         count;
   logic signed [DATA_W-1:0] bias;

   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]    prod_ext, bias_sh;
   logic [7:0]                 act_y;
   logic                       accept;

   assign prod     = $signed(x_in) * $signed(w_in);
   assign prod_ext = ACC_W'(prod);
   assign bias_sh  = ACC_W'(bias) <<< SHIFT;
   assign accept   = in_valid & in_ready;
   assign busy     = (state != IDLE);

   ann_activation #(.ACC_W(ACC_W), .SHIFT(SHIFT)) u_act (
      .acc (acc),
      .y   (act_y)
   );

   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      case (state)
         IDLE: begin
            in_ready = ena & ~bias_wr;
            if (in_valid & in_ready)
               state_nx = (N_INPUTS == 1) ? ACT : ACCUM;
         end
         ACCUM: begin
            in_ready = ena;
            if (in_valid & in_ready && count == CNT_W'(N_INPUTS - 1))
               state_nx = ACT;
         end
         ACT:  state_nx = HOLD;
         HOLD: if (out_valid & out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         acc       <= '0;
         count     <= '0;
         bias      <= '0;
         y_out     <= '0;
         out_valid <= 1'b0;
      end else if (ena) begin
         state <= state_nx;
         case (state)
            IDLE: begin
               // bias_wr takes the cycle; in_ready is already low so no pair is taken.
               if (bias_wr)
                  bias <= $signed(w_in);
               else if (accept) begin
                  acc   <= bias_sh + prod_ext;
                  count <= CNT_W'(1);
               end
            end
            ACCUM: begin
               if (accept) begin
                  acc   <= acc + prod_ext;
                  count <= count + 1'b1;
               end
            end
            ACT: begin
               y_out     <= DATA_W'($signed(act_y));
               out_valid <= 1'b1;
            end
            HOLD: if (out_ready) out_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ann_neuron_mac.sv
// Directed bench for ann_neuron_mac with an expected-result queue.
module tb_ann_neuron_mac;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b0;
   logic       bias_wr = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] x_in = '0;
   logic [7:0] w_in = '0;
   logic       in_ready, out_valid, busy;
   logic [7:0] y_out;

   int n_vec = 0;
   int n_err = 0;
   logic signed [7:0] exp_q[$];

   ann_neuron_mac dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .bias_wr   (bias_wr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x_in      (x_in),
      .w_in      (w_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y_out     (y_out),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic send_pair(input int x, input int w);
      int k;
      @(posedge clk); #1;
      in_valid = 1'b1;
      x_in = 8'(x);
      w_in = 8'(w);
      k = 0;
      @(negedge clk);
      while (!in_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 1);
   endtask

   task automatic stall();
      @(posedge clk); #1;
      ena = 1'b0;
      in_valid = 1'b1;
      x_in = 8'd100;
      w_in = 8'd100;
      repeat (3) begin
         @(negedge clk);
         chk("stall_in_ready", 32'(in_ready), 0);
         chk("stall_busy", 32'(busy), 1);
      end
      @(posedge clk); #1;
      ena = 1'b1;
      in_valid = 1'b0;
   endtask

   task automatic write_bias(input int b);
      @(posedge clk); #1;
      bias_wr = 1'b1;
      w_in = 8'(b);
      @(posedge clk); #1;
      bias_wr = 1'b0;
   endtask

   task automatic frame(input int x, input int w, input logic signed [7:0] expy,
                        input int hold, input int stall_at);
      int k;
      logic signed [7:0] e;
      exp_q.push_back(expy);
      for (int i = 0; i < 4; i++) begin
         if (i == stall_at) stall();
         send_pair(x, w);
      end
      @(posedge clk); #1;            // last pair accepted on this edge
      in_valid = 1'b0;
      @(negedge clk);
      chk("act_out_valid_low", 32'(out_valid), 0);
      chk("act_in_ready_low", 32'(in_ready), 0);
      @(negedge clk);
      chk("latency_out_valid", 32'(out_valid), 1);
      repeat (hold) begin
         @(negedge clk);
         chk("hold_y", $signed(y_out), expy);
         chk("hold_valid", 32'(out_valid), 1);
         chk("hold_in_ready", 32'(in_ready), 0);
         chk("hold_busy", 32'(busy), 1);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      k = 0;
      @(negedge clk);
      while (!out_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 1);
      else if (exp_q.size() == 0) chk("scoreboard_empty", 32'(exp_q.size()), 1);
      else begin
         e = exp_q.pop_front();
         chk("y_out", $signed(y_out), e);
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("after_out_valid", 32'(out_valid), 0);
      chk("after_busy", 32'(busy), 0);
   endtask

   initial begin
      // reset state
      #12;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_y_out", $signed(y_out), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      ena = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 1);

      frame(16, 16, 8'sd64, 0, -1);
      frame(16, 16, 8'sd64, 0, 2);      // ena stall mid-ACCUM
      frame(16, 16, 8'sd64, 5, -1);     // backpressure

      // bias_wr beats in_valid in IDLE
      @(posedge clk); #1;
      bias_wr = 1'b1;
      in_valid = 1'b1;
      w_in = 8'(-5);
      x_in = 8'd9;
      @(negedge clk);
      chk("prio_in_ready", 32'(in_ready), 0);
      @(posedge clk); #1;
      bias_wr = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("prio_busy", 32'(busy), 0);

      frame(8, 8, 8'sd11, 0, -1);       // -80 + 256 = 176 -> 11
      frame(8, 8, 8'sd11, 0, -1);       // bias persists

      write_bias(0);
`ifdef ANN_LEAKY_RELU_EN
      frame(-10, 20, -8'sd7, 0, -1);
`else
      frame(-10, 20, 8'sd0, 0, -1);
`endif
      write_bias(-5);
      frame(127, 127, 8'sd127, 0, -1);

      // reset in the middle of a frame
      send_pair(16, 16);
      send_pair(16, 16);
      @(posedge clk); #1;
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_out_valid", 32'(out_valid), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_y_out", $signed(y_out), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_in_ready", 32'(in_ready), 1);
      frame(16, 16, 8'sd64, 0, -1);     // bias back to 0

      chk("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
